// File: rtl/tw_row_sender.sv
// ---------------------------------------------------------------------------
// tw_row_sender
//
// Builds one row of Goldilocks powers seed*step^k mod p, where
// p = 2^64 - 2^32 + 1 and k = 0..ROW_LEN-1. The row is then written into the
// first-stage twiddle buffer of the twiddle ROM as one unbroken burst of
// write strobes. The strobes must not have gaps because the ROM clears its
// write index whenever the strobe drops.
//
// Ports
//   CLK                 in   1        clock, rising edge
//   rst_n               in   1        asynchronous, active-low reset
//   start               in   1        request one row (sampled only in IDLE)
//   seed                in   P_WIDTH  word 0 of the row
//   step                in   P_WIDTH  ratio between consecutive words
//   horizontal_data_in  out  P_WIDTH  registered row word to the ROM
//   ROM0_w              out  1        registered write strobe to the ROM
//   busy                out  1        high while the row is computed and sent
//   done                out  1        one-cycle pulse after the burst
// ---------------------------------------------------------------------------
module tw_row_sender #(
    parameter int P_WIDTH = 64,
    parameter int ROW_LEN = 4
) (
    input  logic               CLK,
    input  logic               rst_n,
    input  logic               start,
    input  logic [P_WIDTH-1:0] seed,
    input  logic [P_WIDTH-1:0] step,
    output logic [P_WIDTH-1:0] horizontal_data_in,
    output logic               ROM0_w,
    output logic               busy,
    output logic               done
);

    localparam logic [P_WIDTH-1:0] P_MOD = 64'hFFFF_FFFF_0000_0001;
    localparam int                 IW    = $clog2(ROW_LEN);
    localparam logic [IW-1:0]      LAST  = IW'(ROW_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        MUL_P,
        MUL_R,
        SEND,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          k_q, k_d;
    logic [IW-1:0]          i_q, i_d;
    logic [P_WIDTH-1:0]     step_q, step_d;
    logic [P_WIDTH-1:0]     word_q [ROW_LEN];
    logic [P_WIDTH-1:0]     word_d [ROW_LEN];
    logic [2*P_WIDTH-1:0]   prod_q, prod_d;
    logic [P_WIDTH-1:0]     data_q, data_d;
    logic                   romW_q, romW_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Inputs may be anywhere in [0, 2^64). Every such value is below 2p,
    // so one conditional subtraction makes it canonical.
    function automatic logic [P_WIDTH-1:0] canon(input logic [P_WIDTH-1:0] x);
        return (x >= P_MOD) ? (x - P_MOD) : x;
    endfunction

    // Goldilocks reduction of a 128-bit product {d, c, a}, using
    // 2^64 = 2^32 - 1 and 2^96 = -1 (mod p). t0 is never pushed below zero
    // by the borrow fix, and r never overflows again after the carry fix,
    // so one final subtraction of p gives a canonical result.
    function automatic logic [P_WIDTH-1:0] goldReduce(input logic [2*P_WIDTH-1:0] prod);
        logic [63:0] a;
        logic [31:0] c;
        logic [31:0] d;
        logic [64:0] diff;
        logic [64:0] sum;
        logic [63:0] t0;
        logic [63:0] t1;
        logic [63:0] r;
        a    = prod[63:0];
        c    = prod[95:64];
        d    = prod[127:96];
        diff = {1'b0, a} - {33'b0, d};
        t0   = diff[63:0];
        if (diff[64]) t0 = t0 - 64'h0000_0000_FFFF_FFFF;
        t1   = {c, 32'b0} - {32'b0, c};
        sum  = {1'b0, t0} + {1'b0, t1};
        r    = sum[63:0];
        if (sum[64]) r = r + 64'h0000_0000_FFFF_FFFF;
        if (r >= P_MOD) r = r - P_MOD;
        return r;
    endfunction

    // State register and all datapath/output registers. The outputs are
    // registered copies of values derived from the next state. This makes
    // ROM0_w, busy and done line up with the state they describe, and an
    // async reset drops the strobe immediately.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            i_q     <= '0;
            step_q  <= '0;
            word_q  <= '{default: '0};
            prod_q  <= '0;
            data_q  <= '0;
            romW_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            i_q     <= i_d;
            step_q  <= step_d;
            word_q  <= word_d;
            prod_q  <= prod_d;
            data_q  <= data_d;
            romW_q  <= romW_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. Each power takes two cycles: one cycle multiplies
    // into the product register, the next reduces and stores the word.
    // After the row is built, SEND walks the word registers one per cycle.
    // The output registers are then loaded from the state being entered.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        i_d     = i_q;
        step_d  = step_q;
        word_d  = word_q;
        prod_d  = prod_q;
        data_d  = data_q;
        romW_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    step_d    = canon(step);
                    word_d[0] = canon(seed);
                    k_d       = IW'(1);
                    state_d   = MUL_P;
                end
            end
            MUL_P: begin
                prod_d  = {{P_WIDTH{1'b0}}, word_q[k_q - IW'(1)]}
                        * {{P_WIDTH{1'b0}}, step_q};
                state_d = MUL_R;
            end
            MUL_R: begin
                word_d[k_q] = goldReduce(prod_q);
                if (k_q == LAST) begin
                    i_d     = '0;
                    state_d = SEND;
                end else begin
                    k_d     = k_q + IW'(1);
                    state_d = MUL_P;
                end
            end
            SEND: begin
                i_d = i_q + IW'(1);
                if (i_q == LAST) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == MUL_P) || (state_d == MUL_R) || (state_d == SEND);
        done_d = (state_d == DONE);
        romW_d = (state_d == SEND);
        if (romW_d) data_d = word_q[i_d];
    end

    assign horizontal_data_in = data_q;
    assign ROM0_w             = romW_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule

// File: tb/tb_tw_row_sender.sv
// ---------------------------------------------------------------------------
// tb_tw_row_sender
//
// Directed bench for tw_row_sender with ROW_LEN = 4. Each row request is
// followed cycle by cycle. Cycle 0 is the cycle in which start is sampled.
// Strobes are expected in cycles 7..10, done in cycle 11, and IDLE in
// cycle 12. The expected row words are worked out by hand in Goldilocks
// arithmetic.
// ---------------------------------------------------------------------------
module tb_tw_row_sender;

    localparam logic [63:0] P = 64'hFFFF_FFFF_0000_0001;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] seed;
    logic [63:0] step;
    logic [63:0] horizontal_data_in;
    logic        ROM0_w;
    logic        busy;
    logic        done;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [63:0] expRow [4];

    tw_row_sender #(
        .P_WIDTH (64),
        .ROW_LEN (4)
    ) dut (
        .CLK                (CLK),
        .rst_n              (rst_n),
        .start              (start),
        .seed               (seed),
        .step               (step),
        .horizontal_data_in (horizontal_data_in),
        .ROM0_w             (ROM0_w),
        .busy               (busy),
        .done               (done)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 CLK = ~CLK;

    // Compares one observed value against its expected value and records
    // the result.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
        end
    endtask

    // Drives the request inputs.
    task automatic applyStimulus(input logic st, input logic [63:0] sd, input logic [63:0] sp);
        start = st;
        seed  = sd;
        step  = sp;
    endtask

    // Moves to just after the next rising edge, so sampling stays clear of it.
    task automatic stepCycle();
        @(posedge CLK);
        #1;
    endtask

    // Issues one row request in the current cycle (cycle 0) and checks
    // cycles 1..12. startMask[c] is the start level driven during cycle c,
    // so bit 12 = 1 chains straight into the next request. After
    // acceptance, seed and step are replaced with junk. This must not
    // affect the row.
    task automatic runRow(input string tag, input logic [63:0] sd, input logic [63:0] sp,
                          input logic [12:1] startMask);
        logic [63:0] expStrobe;
        logic [63:0] expBusy;
        logic [63:0] expDone;
        applyStimulus(1'b1, sd, sp);
        for (int c = 1; c <= 12; c++) begin
            stepCycle();
            applyStimulus(startMask[c], {$urandom, $urandom}, {$urandom, $urandom});
            expStrobe = (c >= 7 && c <= 10) ? 64'd1 : 64'd0;
            expBusy   = (c >= 1 && c <= 10) ? 64'd1 : 64'd0;
            expDone   = (c == 11) ? 64'd1 : 64'd0;
            checkOutput($sformatf("%s c%0d strobe", tag, c), {63'b0, ROM0_w}, expStrobe);
            checkOutput($sformatf("%s c%0d busy", tag, c), {63'b0, busy}, expBusy);
            checkOutput($sformatf("%s c%0d done", tag, c), {63'b0, done}, expDone);
            if (c >= 7 && c <= 10)
                checkOutput($sformatf("%s word%0d", tag, c - 7), horizontal_data_in, expRow[c - 7]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 64'd0, 64'd0);

        // Reset state
        repeat (3) stepCycle();
        checkOutput("reset strobe", {63'b0, ROM0_w}, 64'd0);
        checkOutput("reset busy", {63'b0, busy}, 64'd0);
        checkOutput("reset done", {63'b0, done}, 64'd0);
        checkOutput("reset data", horizontal_data_in, 64'd0);
        rst_n = 1'b1;
        stepCycle();

        // Basic row: powers of two
        expRow = '{64'd1, 64'd2, 64'd4, 64'd8};
        runRow("basic", 64'd1, 64'd2, 12'h000);

        // Wrap reduction through 2^64 = 2^32 - 1
        expRow = '{64'h1, 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000};
        runRow("wrap", 64'd1, 64'h0000_0001_0000_0000, 12'h000);

        // Negation: step = -1
        expRow = '{64'd3, P - 64'd3, 64'd3, P - 64'd3};
        runRow("negate", 64'd3, P - 64'd1, 12'h000);

        // Non-canonical seed reduced at capture
        expRow = '{64'd5, 64'd5, 64'd5, 64'd5};
        runRow("noncanon", P + 64'd5, 64'd1, 12'h000);

        // (-1)^k: borrow path and final subtraction of p
        expRow = '{P - 64'd1, 64'd1, P - 64'd1, 64'd1};
        runRow("negsq", P - 64'd1, P - 64'd1, 12'h000);

        // -2^(33k): carry path; -2^33, -2^66, -2^99 = 8
        expRow = '{P - 64'd1, 64'hFFFF_FFFD_0000_0001, 64'hFFFF_FFFB_0000_0005, 64'd8};
        runRow("carry", P - 64'd1, 64'h0000_0002_0000_0000, 12'h000);

        // start pulses in cycles 2 and 9 are ignored, then no second burst
        expRow = '{64'd1, 64'd2, 64'd4, 64'd8};
        runRow("busy", 64'd1, 64'd2, 12'h102);
        for (int c = 0; c < 12; c++) begin
            checkOutput($sformatf("after busy c%0d strobe", c), {63'b0, ROM0_w}, 64'd0);
            checkOutput($sformatf("after busy c%0d busy", c), {63'b0, busy}, 64'd0);
            stepCycle();
        end

        // Reset in the middle of a burst
        applyStimulus(1'b1, 64'd1, 64'd2);
        for (int c = 1; c <= 8; c++) begin
            stepCycle();
            applyStimulus(1'b0, 64'd0, 64'd0);
        end
        checkOutput("midburst strobe before reset", {63'b0, ROM0_w}, 64'd1);
        checkOutput("midburst word1", horizontal_data_in, 64'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("midburst reset strobe", {63'b0, ROM0_w}, 64'd0);
        checkOutput("midburst reset busy", {63'b0, busy}, 64'd0);
        checkOutput("midburst reset done", {63'b0, done}, 64'd0);
        checkOutput("midburst reset data", horizontal_data_in, 64'd0);
        stepCycle();
        stepCycle();
        rst_n = 1'b1;
        stepCycle();
        expRow = '{64'd1, 64'd2, 64'd4, 64'd8};
        runRow("after reset", 64'd1, 64'd2, 12'h000);

        // start held high: a new row every 12 cycles
        expRow = '{64'd1, 64'd2, 64'd4, 64'd8};
        runRow("b2b row0", 64'd1, 64'd2, 12'hFFF);
        expRow = '{64'd3, P - 64'd3, 64'd3, P - 64'd3};
        runRow("b2b row1", 64'd3, P - 64'd1, 12'hFFF);
        expRow = '{64'd5, 64'd5, 64'd5, 64'd5};
        runRow("b2b row2", P + 64'd5, 64'd1, 12'h7FF);
        stepCycle();
        checkOutput("b2b end busy", {63'b0, busy}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
